// File: rtl/instr_fetch_assembler_pkg.sv
// Shared ISA definitions: opcodes, register index width, program origin,
// the assembled instruction record and the fetch sequencer states.
package isa_pkg;

  localparam int unsigned REG_W      = 4;
  localparam int unsigned PROG_START = 8;

  localparam logic [REG_W-1:0] OP_ADD = 4'd0;
  localparam logic [REG_W-1:0] OP_SUB = 4'd1;
  localparam logic [REG_W-1:0] OP_MUL = 4'd2;
  localparam logic [REG_W-1:0] OP_DIV = 4'd3;
  localparam logic [REG_W-1:0] OP_END = 4'd4;

  typedef struct packed {
    logic [REG_W-1:0] op;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
  } instr_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_OP,
    S_RD,
    S_RS1,
    S_RS2,
    S_DRAIN,
    S_DONE,
    S_HALT
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_assembler_if.sv
// Assembled-instruction stream: valid/ready handshake plus the head fields.
interface instr_fetch_assembler_if;
  import isa_pkg::*;

  logic             instr_valid;
  logic             instr_ready;
  logic [REG_W-1:0] instr_op;
  logic [REG_W-1:0] instr_rd;
  logic [REG_W-1:0] instr_rs1;
  logic [REG_W-1:0] instr_rs2;

  modport master (
    output instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2,
    input  instr_ready
  );

  modport slave (
    input  instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2,
    output instr_ready
  );

endinterface

// File: rtl/instr_fetch_assembler_fifo.sv
// Synchronous FIFO of instr_t; head is read combinationally, push on full is
// accepted only when a pop happens in the same cycle.
module instr_fifo
  import isa_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  instr_t push_data,
  input  logic   pop,
  output instr_t head,
  output logic   full,
  output logic   empty
);

  localparam int unsigned PW = $clog2(DEPTH);

  instr_t        mem [DEPTH];
  logic [PW:0]   wr_ptr;
  logic [PW:0]   rd_ptr;
  logic          pop_ok;
  logic          push_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign head    = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr[PW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/instr_fetch_assembler.sv
// Walks nibble-wide program memory, assembles {op,rd,rs1,rs2} into a FIFO.
// Optional `ILLEGAL_OP_TRAP_EN: opcodes above END trap to HALT with err set.
module instr_fetch_assembler
  import isa_pkg::*;
#(
  parameter int unsigned ADDR_W     = 6,
  parameter int unsigned START_ADDR = PROG_START,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic [REG_W-1:0]        mem_data,
  instr_fetch_assembler_if.master instr,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  fetch_state_t     state, state_n;
  logic [ADDR_W-1:0] addr_n;
  logic [REG_W-1:0]  op_q, rd_q, rs1_q;
  logic              ld_op, ld_rd, ld_rs1;
  logic              push, pop, fifo_full, fifo_empty;
  logic              err_n, done_n, addr_last;
  instr_t            push_data, head;

  assign addr_last = (mem_addr == '1);
  assign push_data = '{op: op_q, rd: rd_q, rs1: rs1_q, rs2: mem_data};
  assign pop       = instr.instr_valid & instr.instr_ready;
  assign busy      = (state == S_OP) || (state == S_RD) || (state == S_RS1) ||
                     (state == S_RS2) || (state == S_DRAIN);

  assign instr.instr_valid = ~fifo_empty;
  assign instr.instr_op    = head.op;
  assign instr.instr_rd    = head.rd;
  assign instr.instr_rs1   = head.rs1;
  assign instr.instr_rs2   = head.rs2;

  instr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      mem_addr <= ADDR_W'(START_ADDR);
      op_q     <= '0;
      rd_q     <= '0;
      rs1_q    <= '0;
      err      <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      mem_addr <= addr_n;
      err      <= err_n;
      done     <= done_n;
      if (ld_op)  op_q  <= mem_data;
      if (ld_rd)  rd_q  <= mem_data;
      if (ld_rs1) rs1_q <= mem_data;
    end
  end

  // A fetch at the last address cannot advance: anything but END there is overflow.
  always_comb begin
    state_n = state;
    addr_n  = mem_addr;
    err_n   = err;
    done_n  = done;
    ld_op   = 1'b0;
    ld_rd   = 1'b0;
    ld_rs1  = 1'b0;
    push    = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_n = S_OP;
          addr_n  = ADDR_W'(START_ADDR);
          done_n  = 1'b0;
        end
      end
      S_OP: begin
        if (!fifo_full) begin
          if (mem_data == OP_END) begin
            state_n = S_DRAIN;
            if (!addr_last) addr_n = mem_addr + 1'b1;
          end
`ifdef ILLEGAL_OP_TRAP_EN
          else if (mem_data > OP_END) begin
            err_n   = 1'b1;
            state_n = S_HALT;
          end
`endif
          else begin
            ld_op = 1'b1;
            if (addr_last) begin
              err_n   = 1'b1;
              state_n = S_HALT;
            end else begin
              addr_n  = mem_addr + 1'b1;
              state_n = S_RD;
            end
          end
        end
      end
      S_RD: begin
        ld_rd = 1'b1;
        if (addr_last) begin
          err_n   = 1'b1;
          state_n = S_HALT;
        end else begin
          addr_n  = mem_addr + 1'b1;
          state_n = S_RS1;
        end
      end
      S_RS1: begin
        ld_rs1 = 1'b1;
        if (addr_last) begin
          err_n   = 1'b1;
          state_n = S_HALT;
        end else begin
          addr_n  = mem_addr + 1'b1;
          state_n = S_RS2;
        end
      end
      S_RS2: begin
        push = 1'b1;
        if (addr_last) begin
          err_n   = 1'b1;
          state_n = S_HALT;
        end else begin
          addr_n  = mem_addr + 1'b1;
          state_n = S_OP;
        end
      end
      S_DRAIN: begin
        if (fifo_empty) begin
          state_n = S_DONE;
          done_n  = 1'b1;
        end
      end
      S_HALT: ;
      default: state_n = S_IDLE;
    endcase
  end

endmodule
